// File: rtl/fetch_redirect_controller.sv
// Fetch redirect controller.
// Chooses the next-PC source for the fetch-issue PC register. It arbitrates
// trap, branch and jump redirects, and gates PC advance on stall and on
// instruction-cache readiness. When the cache cannot take a redirect yet,
// the winning redirect is held in a one-entry buffer until it can be applied.
module fetch_redirect_controller #(
  parameter int unsigned CORE         = 0,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned COUNT_BITS   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    trap_valid,
  input  logic [ADDRESS_BITS-1:0] trap_target,
  input  logic                    branch_valid,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic                    jump_valid,
  input  logic [ADDRESS_BITS-1:0] jump_target,
  input  logic                    pipeline_stall,
  input  logic                    i_mem_ready,
  output logic [1:0]              next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    flush_fetch,
  output logic                    redirect_pending,
  output logic [COUNT_BITS-1:0]   redirect_count
);

  localparam int unsigned BOOT_BITS = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int unsigned RANK_BITS = 2;

  localparam logic [1:0] SEL_INC  = 2'b00;
  localparam logic [1:0] SEL_HOLD = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;

  localparam logic [RANK_BITS-1:0] RANK_NONE   = 2'd0;
  localparam logic [RANK_BITS-1:0] RANK_JUMP   = 2'd1;
  localparam logic [RANK_BITS-1:0] RANK_BRANCH = 2'd2;
  localparam logic [RANK_BITS-1:0] RANK_TRAP   = 2'd3;

  // A boot window of zero cycles is not supported.
  if (BOOT_CYCLES < 1) begin : g_boot_check
    $error("fetch_redirect_controller core %0d: BOOT_CYCLES must be at least 1", CORE);
  end

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [BOOT_BITS-1:0]    boot_cnt, boot_cnt_next;
  logic [ADDRESS_BITS-1:0] pend_target, pend_target_next;
  logic [RANK_BITS-1:0]    pend_rank, pend_rank_next;
  logic [RANK_BITS-1:0]    win_rank;
  logic [ADDRESS_BITS-1:0] win_target;
  logic                    take_new;
  logic                    apply;

  // Highest-rank valid redirect source this cycle.
  always_comb begin
    win_rank   = RANK_NONE;
    win_target = '0;
    if (trap_valid) begin
      win_rank   = RANK_TRAP;
      win_target = trap_target;
    end else if (branch_valid) begin
      win_rank   = RANK_BRANCH;
      win_target = branch_target;
    end else if (jump_valid) begin
      win_rank   = RANK_JUMP;
      win_target = jump_target;
    end
  end

  // A new redirect of equal or higher rank supersedes the buffered one;
  // a lower-rank one comes from a younger wrong-path instruction and is dropped.
  assign take_new = (win_rank != RANK_NONE) && (win_rank >= pend_rank);

  // Next-state, buffer update and next-PC outputs.
  always_comb begin
    state_next       = state;
    boot_cnt_next    = boot_cnt;
    pend_target_next = pend_target;
    pend_rank_next   = pend_rank;
    next_PC_select   = SEL_HOLD;
    target_PC        = '0;
    flush_fetch      = 1'b0;
    apply            = 1'b0;
    case (state)
      BOOT: begin
        if (boot_cnt == BOOT_BITS'(BOOT_CYCLES - 1)) begin
          state_next = RUN;
        end else begin
          boot_cnt_next = boot_cnt + BOOT_BITS'(1);
        end
      end
      RUN: begin
        if (win_rank != RANK_NONE) begin
          if (i_mem_ready) begin
            next_PC_select = SEL_LOAD;
            target_PC      = win_target;
            flush_fetch    = 1'b1;
            apply          = 1'b1;
          end else begin
            pend_target_next = win_target;
            pend_rank_next   = win_rank;
            state_next       = PENDING;
          end
        end else if (pipeline_stall || !i_mem_ready) begin
          next_PC_select = SEL_HOLD;
        end else begin
          next_PC_select = SEL_INC;
        end
      end
      PENDING: begin
        if (take_new) begin
          pend_target_next = win_target;
          pend_rank_next   = win_rank;
        end
        if (i_mem_ready) begin
          next_PC_select   = SEL_LOAD;
          target_PC        = take_new ? win_target : pend_target;
          flush_fetch      = 1'b1;
          apply            = 1'b1;
          pend_target_next = '0;
          pend_rank_next   = RANK_NONE;
          state_next       = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign redirect_pending = (state == PENDING);

  // State, boot counter and pending buffer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      pend_target <= '0;
      pend_rank   <= RANK_NONE;
    end else begin
      state       <= state_next;
      boot_cnt    <= boot_cnt_next;
      pend_target <= pend_target_next;
      pend_rank   <= pend_rank_next;
    end
  end

  // Saturating count of applied redirects.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      redirect_count <= '0;
    end else if (apply && (redirect_count != {COUNT_BITS{1'b1}})) begin
      redirect_count <= redirect_count + COUNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Testbench for fetch_redirect_controller: directed scenarios followed by
// random traffic, all checked against a cycle-level reference model.
module tb_fetch_redirect_controller;

  localparam int unsigned AB   = 20;
  localparam int unsigned BOOT = 2;
  localparam int unsigned CB   = 4;
  localparam int          CMAX = (1 << CB) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          trap_valid = 1'b0, branch_valid = 1'b0, jump_valid = 1'b0;
  logic [AB-1:0] trap_target = '0, branch_target = '0, jump_target = '0;
  logic          pipeline_stall = 1'b0, i_mem_ready = 1'b0;
  logic [1:0]    next_PC_select;
  logic [AB-1:0] target_PC;
  logic          flush_fetch;
  logic          redirect_pending;
  logic [CB-1:0] redirect_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: boot cycles left, buffered redirect, applied count.
  int            m_boot_left;
  bit            m_pend;
  int            m_pend_rank;
  logic [AB-1:0] m_pend_tgt;
  int            m_count;

  // Last observed outputs of a step, for explicit scenario checks.
  logic [1:0]    obs_sel;
  logic [AB-1:0] obs_tgt;

  fetch_redirect_controller #(
    .CORE(0), .ADDRESS_BITS(AB), .BOOT_CYCLES(BOOT), .COUNT_BITS(CB)
  ) dut (
    .clock(clock), .reset(reset),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .pipeline_stall(pipeline_stall), .i_mem_ready(i_mem_ready),
    .next_PC_select(next_PC_select), .target_PC(target_PC),
    .flush_fetch(flush_fetch), .redirect_pending(redirect_pending),
    .redirect_count(redirect_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot_left = BOOT;
    m_pend      = 1'b0;
    m_pend_rank = 0;
    m_pend_tgt  = '0;
    m_count     = 0;
  endtask

  // Assert reset now (between edges), check the reset outputs, hold for n edges.
  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_sel", 32'(next_PC_select), 32'd1);
    chk("rst_tgt", 32'(target_PC), 32'd0);
    chk("rst_flush", 32'(flush_fetch), 32'd0);
    chk("rst_pend", 32'(redirect_pending), 32'd0);
    chk("rst_count", 32'(redirect_count), 32'd0);
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict outputs, check mid-cycle, advance model.
  task automatic step(input logic tv, input logic [AB-1:0] tt,
                      input logic bv, input logic [AB-1:0] bt,
                      input logic jv, input logic [AB-1:0] jt,
                      input logic stall, input logic ready);
    int            w;
    logic [AB-1:0] wt;
    int            e_sel;
    logic [AB-1:0] e_tgt;
    bit            e_flush, applied;
    int            eff_rank;
    logic [AB-1:0] eff_tgt;
    trap_valid = tv; trap_target = tt;
    branch_valid = bv; branch_target = bt;
    jump_valid = jv; jump_target = jt;
    pipeline_stall = stall; i_mem_ready = ready;

    w = 0; wt = '0;
    if (tv) begin w = 3; wt = tt; end
    else if (bv) begin w = 2; wt = bt; end
    else if (jv) begin w = 1; wt = jt; end

    e_sel = 1; e_tgt = '0; e_flush = 0; applied = 0;
    eff_rank = 0; eff_tgt = '0;
    if (m_boot_left > 0) begin
      e_sel = 1;
    end else if (!m_pend) begin
      if (w > 0) begin
        eff_rank = w; eff_tgt = wt;
        if (ready) applied = 1;
      end else begin
        e_sel = (stall || !ready) ? 1 : 0;
      end
    end else begin
      if (w > 0 && w >= m_pend_rank) begin eff_rank = w; eff_tgt = wt; end
      else begin eff_rank = m_pend_rank; eff_tgt = m_pend_tgt; end
      if (ready) applied = 1;
    end
    if (applied) begin e_sel = 2; e_tgt = eff_tgt; e_flush = 1; end

    @(negedge clock);
    obs_sel = next_PC_select;
    obs_tgt = target_PC;
    chk("sel", 32'(next_PC_select), 32'(e_sel));
    chk("tgt", 32'(target_PC), 32'(e_tgt));
    chk("flush", 32'(flush_fetch), 32'(e_flush));
    chk("pend", 32'(redirect_pending), 32'(m_pend));
    chk("count", 32'(redirect_count), 32'(m_count));

    @(posedge clock);
    #1;
    if (m_boot_left > 0) begin
      m_boot_left--;
    end else if (applied) begin
      m_pend = 0; m_pend_rank = 0; m_pend_tgt = '0;
      if (m_count < CMAX) m_count++;
    end else if (eff_rank > 0) begin
      m_pend = 1; m_pend_rank = eff_rank; m_pend_tgt = eff_tgt;
    end
  endtask

  task automatic idle(input logic stall, input logic ready);
    step(0, '0, 0, '0, 0, '0, stall, ready);
  endtask

  initial begin
    model_reset();
    #2;
    do_reset(3);

    // Boot window then free-running fetch.
    idle(0, 1);
    chk("boot_hold1", 32'(obs_sel), 32'd1);
    idle(0, 1);
    chk("boot_hold2", 32'(obs_sel), 32'd1);
    repeat (3) idle(0, 1);
    chk("run_inc", 32'(obs_sel), 32'd0);

    // Single jump redirect.
    step(0, '0, 0, '0, 1, 20'h00100, 0, 1);
    chk("jump_tgt", 32'(obs_tgt), 32'h00100);
    idle(0, 1);
    chk("jump_after", 32'(obs_sel), 32'd0);
    chk("jump_count", 32'(redirect_count), 32'd1);

    // All three sources at once: trap wins, counted once.
    step(1, 20'h0F000, 1, 20'h00200, 1, 20'h00300, 0, 1);
    chk("prio_tgt", 32'(obs_tgt), 32'h0F000);
    idle(0, 1);
    chk("prio_count", 32'(redirect_count), 32'd2);

    // Buffered branch, lower-rank jump dropped, trap replaces, then applied.
    step(0, '0, 1, 20'h00400, 0, '0, 0, 0);
    chk("pend_hold", 32'(obs_sel), 32'd1);
    step(0, '0, 0, '0, 1, 20'h00500, 0, 0);
    step(1, 20'h0F000, 0, '0, 0, '0, 0, 0);
    idle(0, 1);
    chk("pend_apply_sel", 32'(obs_sel), 32'd2);
    chk("pend_apply_tgt", 32'(obs_tgt), 32'h0F000);
    idle(0, 1);

    // Redirect overrides stall; stall then holds.
    step(0, '0, 1, 20'h00040, 0, '0, 1, 1);
    chk("stall_redirect", 32'(obs_sel), 32'd2);
    idle(1, 1);
    chk("stall_hold", 32'(obs_sel), 32'd1);

    // Saturate the redirect counter.
    for (int i = 0; i < 17; i++) step(0, '0, 0, '0, 1, AB'(i * 4), 0, 1);
    idle(0, 1);
    chk("sat_count", 32'(redirect_count), 32'(CMAX));

    // Reset while a redirect is buffered discards it.
    step(0, '0, 1, 20'h00800, 0, '0, 0, 0);
    chk("pre_rst_pend", 32'(redirect_pending), 32'd1);
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      idle(0, 1);
      chk("post_rst_noload", 32'(obs_sel == 2'd2), 32'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) == 0, AB'($urandom),
           $urandom_range(0, 6) == 0, AB'($urandom),
           $urandom_range(0, 4) == 0, AB'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
